rd3_in_grp: RTL and testbench

RD3_IN_GRP -- requirements
Module: rd3_in_grp

---
 rtl/rd3_pkg.sv | 23 ++
 rtl/rd3_sbuf.sv | 30 +++
 rtl/rd3_in_grp.sv | 157 +++++++++++++++
 tb/tb_rd3_in_grp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rd3_pkg.sv
// Shared definitions for the radix-3 input regrouping block: sample width
// derivation, FSM state encoding and index counter width.
package rd3_pkg;

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        EMIT   = 2'd2
    } rd3_state_e;

    // Total sample width from its sign, integer and fraction fields.
    function automatic int calc_dw(input int sign_bit, input int int_bit, input int flt_bit);
        return sign_bit + int_bit + flt_bit;
    endfunction

    // Index counter width: clog2(N3), never narrower than one bit so N3=1 still has a counter.
    function automatic int idx_width(input int n3);
        int w;
        w = $clog2(n3);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rd3_sbuf.sv
// One-third frame buffer: DEPTH-deep register file with a single synchronous
// write port and an asynchronous read port. Contents are intentionally not
// reset; every location is written before it is read within a frame.
module rd3_sbuf
    import rd3_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 26,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the incoming sample into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rd3_in_grp.sv
// Radix-3 input regrouping: turns a serial frame of N = 3*N3 samples into
// N3 parallel triplets (x[k], x[k+N3], x[k+2*N3]). The first third is held in
// buffer A, the second in buffer B, and each sample of the last third is
// emitted together with the matching A/B entries one clock after it arrives.
module rd3_in_grp
    import rd3_pkg::*;
#(
    parameter int SIGN_BIT = 1,
    parameter int INT_BIT  = 6,
    parameter int FLT_BIT  = 6,
    parameter int N3       = 3,
    localparam int DW      = calc_dw(SIGN_BIT, INT_BIT, FLT_BIT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          di_vld,
    input  logic          di_sof,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    output logic          do_vld,
    output logic [DW-1:0] out1_re,
    output logic [DW-1:0] out1_im,
    output logic [DW-1:0] out2_re,
    output logic [DW-1:0] out2_im,
    output logic [DW-1:0] out3_re,
    output logic [DW-1:0] out3_im,
    output logic          frm_done,
    output logic          sync_err
);

    localparam int            IW       = idx_width(N3);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N3 - 1);

    rd3_state_e    state_r, state_nxt_s, eff_state_s;
    logic [IW-1:0] idx_r, idx_nxt_s, eff_idx_s;
    logic          resync_s, last_s, wr_a_s, wr_b_s, emit_s;
    logic [2*DW-1:0] a_rd_s, b_rd_s, din_s;

    logic          do_vld_r, frm_done_r, sync_err_r;
    logic [DW-1:0] out1_re_r, out1_im_r, out2_re_r, out2_im_r, out3_re_r, out3_im_r;

    assign din_s = {di_re, di_im};

    rd3_sbuf #(.DEPTH(N3), .WIDTH(2*DW), .AW(IW)) u_buf_a (
        .clk   (clk),
        .we    (wr_a_s),
        .waddr (eff_idx_s),
        .wdata (din_s),
        .raddr (eff_idx_s),
        .rdata (a_rd_s)
    );

    rd3_sbuf #(.DEPTH(N3), .WIDTH(2*DW), .AW(IW)) u_buf_b (
        .clk   (clk),
        .we    (wr_b_s),
        .waddr (eff_idx_s),
        .wdata (din_s),
        .raddr (eff_idx_s),
        .rdata (b_rd_s)
    );

    // Next-state logic: an unexpected start-of-frame makes the sample behave
    // as if it arrived at (FILL_A, 0); otherwise the current position is used.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_a_s      = 1'b0;
        wr_b_s      = 1'b0;
        emit_s      = 1'b0;
        resync_s    = di_vld && di_sof && !((state_r == FILL_A) && (idx_r == IDX_ZERO));
        if (resync_s) begin
            eff_state_s = FILL_A;
            eff_idx_s   = IDX_ZERO;
        end else begin
            eff_state_s = state_r;
            eff_idx_s   = idx_r;
        end
        last_s = (eff_idx_s == IDX_LAST);
        if (di_vld) begin
            case (eff_state_s)
                FILL_A:  wr_a_s = 1'b1;
                FILL_B:  wr_b_s = 1'b1;
                EMIT:    emit_s = 1'b1;
                default: emit_s = 1'b0;
            endcase
            if (last_s) begin
                idx_nxt_s = IDX_ZERO;
                case (eff_state_s)
                    FILL_A:  state_nxt_s = FILL_B;
                    FILL_B:  state_nxt_s = EMIT;
                    EMIT:    state_nxt_s = FILL_A;
                    default: state_nxt_s = FILL_A;
                endcase
            end else begin
                idx_nxt_s   = eff_idx_s + IDX_ONE;
                state_nxt_s = eff_state_s;
            end
        end else begin
            state_nxt_s = state_r;
            idx_nxt_s   = idx_r;
        end
    end

    // FSM state and index register.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_r <= FILL_A;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered triplet outputs and status pulses; data holds between triplets.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            do_vld_r   <= 1'b0;
            frm_done_r <= 1'b0;
            sync_err_r <= 1'b0;
            out1_re_r  <= {DW{1'b0}};
            out1_im_r  <= {DW{1'b0}};
            out2_re_r  <= {DW{1'b0}};
            out2_im_r  <= {DW{1'b0}};
            out3_re_r  <= {DW{1'b0}};
            out3_im_r  <= {DW{1'b0}};
        end else begin
            sync_err_r <= resync_s;
            if (emit_s) begin
                do_vld_r   <= 1'b1;
                frm_done_r <= last_s;
                out1_re_r  <= a_rd_s[2*DW-1:DW];
                out1_im_r  <= a_rd_s[DW-1:0];
                out2_re_r  <= b_rd_s[2*DW-1:DW];
                out2_im_r  <= b_rd_s[DW-1:0];
                out3_re_r  <= di_re;
                out3_im_r  <= di_im;
            end else begin
                do_vld_r   <= 1'b0;
                frm_done_r <= 1'b0;
            end
        end
    end

    assign do_vld   = do_vld_r;
    assign frm_done = frm_done_r;
    assign sync_err = sync_err_r;
    assign out1_re  = out1_re_r;
    assign out1_im  = out1_im_r;
    assign out2_re  = out2_re_r;
    assign out2_im  = out2_im_r;
    assign out3_re  = out3_re_r;
    assign out3_im  = out3_im_r;

endmodule

// File: tb/tb_rd3_in_grp.sv
// Self-checking bench for rd3_in_grp. The reference model keeps the samples of
// the current frame in a queue; once the queue holds at least 2*N3 samples,
// each new sample completes triplet k = position - 2*N3.
module tb_rd3_in_grp;

    localparam int DW = 13;
    localparam int N3 = 3;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          di_vld = 1'b0;
    logic          di_sof = 1'b0;
    logic [DW-1:0] di_re = '0;
    logic [DW-1:0] di_im = '0;
    logic          do_vld, frm_done, sync_err;
    logic [DW-1:0] out1_re, out1_im, out2_re, out2_im, out3_re, out3_im;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*DW-1:0] frame_q[$];
    logic [6*DW-1:0] exp_out = '0;
    logic            exp_vld = 1'b0;
    logic            exp_fd  = 1'b0;
    logic            exp_se  = 1'b0;

    rd3_in_grp #(.SIGN_BIT(1), .INT_BIT(6), .FLT_BIT(6), .N3(N3)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .di_vld   (di_vld),
        .di_sof   (di_sof),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_vld   (do_vld),
        .out1_re  (out1_re),
        .out1_im  (out1_im),
        .out2_re  (out2_re),
        .out2_im  (out2_im),
        .out3_re  (out3_re),
        .out3_im  (out3_im),
        .frm_done (frm_done),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // One clock of stimulus followed by model update and output checks.
    task automatic drive(input logic vld, input logic sof, input logic [DW-1:0] re, input logic [DW-1:0] im);
        int p;
        int k;
        logic [2*DW-1:0] s;
        logic [6*DW-1:0] act;
        di_vld = vld; di_sof = sof; di_re = re; di_im = im;
        @(posedge clk);
        #1;
        exp_vld = 1'b0; exp_fd = 1'b0; exp_se = 1'b0;
        s = {re, im};
        if (vld) begin
            if (sof && frame_q.size() != 0) begin
                exp_se = 1'b1;
                frame_q.delete();
            end
            p = frame_q.size();
            frame_q.push_back(s);
            if (p >= 2*N3) begin
                k = p - 2*N3;
                exp_out = {frame_q[k], frame_q[k+N3], s};
                exp_vld = 1'b1;
                exp_fd  = (k == N3-1);
            end
            if (frame_q.size() == 3*N3) frame_q.delete();
        end
        di_vld = 1'b0; di_sof = 1'b0;
        act = {out1_re, out1_im, out2_re, out2_im, out3_re, out3_im};
        n_tests++;
        if (do_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL do_vld t=%0t got %b want %b", $time, do_vld, exp_vld);
        end
        n_tests++;
        if (frm_done !== exp_fd) begin
            n_fail++;
            $display("FAIL frm_done t=%0t got %b want %b", $time, frm_done, exp_fd);
        end
        n_tests++;
        if (sync_err !== exp_se) begin
            n_fail++;
            $display("FAIL sync_err t=%0t got %b want %b", $time, sync_err, exp_se);
        end
        n_tests++;
        if (act !== exp_out) begin
            n_fail++;
            $display("FAIL outputs t=%0t got %h want %h", $time, act, exp_out);
        end
    endtask

    // Assert reset, check outputs clear asynchronously, then release.
    task automatic do_reset();
        n_rst = 1'b1;
        #1;
        frame_q.delete();
        exp_out = '0;
        n_tests++;
        if ({do_vld, frm_done, sync_err, out1_re, out1_im, out2_re, out2_im, out3_re, out3_im} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs t=%0t got %b/%b/%b %h %h %h want all zero", $time,
                     do_vld, frm_done, sync_err, {out1_re, out1_im}, {out2_re, out2_im}, {out3_re, out3_im});
        end
        @(posedge clk);
        #1;
        n_rst = 1'b0;
    endtask

    // Send one frame of re = base+1..base+3*N3, im = -re, with gap idle cycles between samples.
    task automatic send_frame(input int base, input int gap);
        logic [DW-1:0] v;
        for (int i = 1; i <= 3*N3; i++) begin
            v = DW'(base + i);
            drive(1'b1, (i == 1), v, -v);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_basic();
        int cnt = 0;
        logic [DW-1:0] v;
        for (int i = 1; i <= 9; i++) begin
            v = DW'(i);
            drive(1'b1, (i == 1), v, -v);
            if (do_vld) cnt++;
        end
        drive(1'b0, 1'b0, '0, '0);
        n_tests++;
        if (cnt !== 3) begin
            n_fail++;
            $display("FAIL basic_pulse_count got %0d want 3", cnt);
        end
    endtask

    task automatic test_gaps();
        send_frame(0, 2);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 0);
        send_frame(10, 0);
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_resync();
        logic [DW-1:0] v;
        for (int i = 1; i <= 13; i++) begin
            v = DW'(i);
            drive(1'b1, (i == 1) || (i == 5), v, -v);
        end
        drive(1'b0, 1'b1, '0, '0);
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] v;
        for (int i = 1; i <= 7; i++) begin
            v = DW'(i);
            drive(1'b1, (i == 1), v, -v);
        end
        do_reset();
        send_frame(0, 0);
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_extremes();
        logic [DW-1:0] mn, mx;
        mn = 13'h1000;
        mx = 13'h0FFF;
        for (int i = 0; i < 3*N3; i++) begin
            if (i % 2 == 0) drive(1'b1, (i == 0), mn, mx);
            else            drive(1'b1, 1'b0, mx, mn);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 12) == 0, DW'($urandom), DW'($urandom));
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_mid_reset();
        test_extremes();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
